muldiv_unit: RTL



---
 rtl/muldiv_pkg.sv | 12 +
 rtl/muldiv_unit.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared state/op types and op classification for the multiply/divide unit
package muldiv_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  typedef enum logic [2:0] {
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } op_e;
  localparam logic [7:0] MUL_OPS = 8'b0000_1111;
  localparam logic [7:0] DIV_OPS = 8'b1111_0000;
  function automatic logic is_div(op_e op);
    return DIV_OPS[op];
  endfunction
endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 RV64M multiply/divide with pipeline stall request
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic            word_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [4:0]      rd_i,
  input  logic            flush_i,
  output logic            stall_req_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o
);
  localparam int CW = $clog2(XLEN) + 1;
  localparam int H  = XLEN / 2;
  state_e              state_q, state_d;
  op_e                 op_q, op_d, op_in;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2*XLEN-1:0]   acc_q, acc_d, acc_init, acc_step, prod, prod_s;
  logic [XLEN-1:0]     b_q, b_d;
  logic [4:0]          rd_q, rd_d;
  logic                word_q, word_d, spec_q, spec_d, neg_q, neg_d, negr_q, negr_d;
  logic                a_sgn, b_sgn, a_sign, b_sign, b_zero, ovf, special, accept, sub;
  logic [XLEN-1:0]     a_sx, b_sx, a_ext, b_ext, a_mag, b_mag, a_w, spec_res, min_val;
  logic [XLEN-1:0]     mul_res, q_s, r_s, d_res, div_res, res;
  logic [XLEN:0]       addx, addy, sum;
  // Decode the incoming op: extend W operands, take magnitudes, detect the single-cycle divide cases
  always_comb begin
    op_in    = op_e'(op_i);
    a_sgn    = op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    b_sgn    = op_in inside {OP_MULH, OP_DIV, OP_REM};
    a_sx     = {{H{a_i[H-1]}}, a_i[H-1:0]};
    b_sx     = {{H{b_i[H-1]}}, b_i[H-1:0]};
    a_ext    = word_i ? (a_sgn ? a_sx : {{H{1'b0}}, a_i[H-1:0]}) : a_i;
    b_ext    = word_i ? (b_sgn ? b_sx : {{H{1'b0}}, b_i[H-1:0]}) : b_i;
    a_sign   = a_sgn & a_ext[XLEN-1];
    b_sign   = b_sgn & b_ext[XLEN-1];
    a_mag    = a_sign ? -a_ext : a_ext;
    b_mag    = b_sign ? -b_ext : b_ext;
    min_val  = word_i ? {{(H+1){1'b1}}, {(H-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
    b_zero   = b_ext == '0;
    ovf      = (op_in inside {OP_DIV, OP_REM}) && a_ext == min_val && &b_ext;
    special  = is_div(op_in) && (b_zero || ovf);
    a_w      = word_i ? a_sx : a_i;
    spec_res = b_zero ? (op_in[1] ? a_w : '1) : (op_in[1] ? '0 : a_w);
    acc_init = {{XLEN{1'b0}}, (is_div(op_in) && word_i) ? a_mag << H : a_mag};
  end
  // One radix-2 step on the shared shift register: shift-add for multiply, restoring subtract for divide
  always_comb begin
    sub      = is_div(op_q);
    addx     = sub ? acc_q[2*XLEN-1:XLEN-1] : {1'b0, acc_q[2*XLEN-1:XLEN]};
    addy     = {1'b0, b_q};
    sum      = addx + (sub ? ~addy : addy) + {{XLEN{1'b0}}, sub};
    acc_step = sub ? (sum[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0} : {sum[XLEN-1:0], acc_q[XLEN-2:0], 1'b1})
                   : (acc_q[0] ? {sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]});
  end
  // Sign correction and result selection, only driven out during DONE
  always_comb begin
    prod     = word_q ? acc_q >> H : acc_q;
    prod_s   = neg_q ? -prod : prod;
    mul_res  = word_q ? {{H{prod_s[H-1]}}, prod_s[H-1:0]}
                      : (op_q == OP_MUL ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN]);
    q_s      = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    r_s      = negr_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    d_res    = op_q[1] ? r_s : q_s;
    div_res  = word_q ? {{H{d_res[H-1]}}, d_res[H-1:0]} : d_res;
    res      = spec_q ? acc_q[XLEN-1:0] : (MUL_OPS[op_q] ? mul_res : div_res);
    result_o = done_o ? res : '0;
    rd_o     = done_o ? rd_q : '0;
  end
  // Control FSM: accept in IDLE, iterate in BUSY, present the result for one cycle in DONE
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    b_d         = b_q;
    op_d        = op_q;
    word_d      = word_q;
    rd_d        = rd_q;
    spec_d      = spec_q;
    neg_d       = neg_q;
    negr_d      = negr_q;
    accept      = 1'b0;
    stall_req_o = 1'b0;
    done_o      = 1'b0;
    case (state_q)
      IDLE: begin
        accept      = start_i & ~flush_i;
        stall_req_o = accept;
        if (accept) begin
          state_d = special ? DONE : BUSY;
          cnt_d   = word_i ? CW'(H) : CW'(XLEN);
          acc_d   = special ? {{XLEN{1'b0}}, spec_res} : acc_init;
          b_d     = b_mag;
          op_d    = op_in;
          word_d  = word_i;
          rd_d    = rd_i;
          spec_d  = special;
          neg_d   = a_sign ^ b_sign;
          negr_d  = a_sign;
        end
      end
      BUSY: begin
        stall_req_o = 1'b1;
        acc_d       = acc_step;
        cnt_d       = cnt_q - 1'b1;
        state_d     = flush_i ? IDLE : (cnt_q == CW'(1) ? DONE : BUSY);
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // State and datapath registers, all cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      b_q     <= '0;
      op_q    <= OP_MUL;
      word_q  <= 1'b0;
      rd_q    <= '0;
      spec_q  <= 1'b0;
      neg_q   <= 1'b0;
      negr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      op_q    <= op_d;
      word_q  <= word_d;
      rd_q    <= rd_d;
      spec_q  <= spec_d;
      neg_q   <= neg_d;
      negr_q  <= negr_d;
    end
  end
endmodule
